// File: rtl/audio_word_engine.sv
// audio_word_engine: packs/unpacks signed audio samples between the AC97
// sample stream and a multi-bank word memory; supports record, playback
// and overdub (play + input mixed and written back to the same word).
module audio_word_engine #(
  parameter  int SAMPLE_W  = 12,
  parameter  int SPW       = 3,
  parameter  int MEM_W     = SAMPLE_W * SPW,
  parameter  int SONG_W    = 4,
  parameter  int BANK_BITS = 1,
  localparam int NUM_BANKS = 2 ** BANK_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ready,
  input  logic [SAMPLE_W-1:0]        audio_in,
  input  logic                       start_song,
  input  logic [SONG_W-1:0]          song_choice,
  input  logic [1:0]                 mode,
  input  logic                       pause_song,
  input  logic                       song_done,
  input  logic [NUM_BANKS*MEM_W-1:0] mem_read,
  output logic [NUM_BANKS-1:0]       we,
  output logic [MEM_W-1:0]           mem_write,
  output logic                       word_adv,
  output logic [SAMPLE_W-1:0]        audio_out,
  output logic                       active
);

  localparam int PH_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [1:0] MODE_PLAY = 2'b00;
  localparam logic [1:0] MODE_REC  = 2'b01;
  localparam logic [1:0] MODE_OVD  = 2'b10;

  if (MEM_W != SAMPLE_W * SPW) begin : g_bad_width
    $error("MEM_W must equal SAMPLE_W*SPW");
  end

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t                     state_q;
  logic [1:0]                 mode_q;
  logic [BANK_BITS-1:0]       bank_q;
  logic [PH_W-1:0]            phase_q;
  logic [MEM_W-1:0]           pack_q;
  logic [MEM_W-1:0]           play_q;
  logic [NUM_BANKS-1:0]       we_q;
  logic [MEM_W-1:0]           mem_write_q;
  logic                       word_adv_q;
  logic [SAMPLE_W-1:0]        audio_out_q;

  logic [NUM_BANKS*MEM_W-1:0] rd_sh;
  logic [MEM_W-1:0]           rd_word;
  logic [MEM_W-1:0]           cur_word;
  logic [MEM_W-1:0]           pack_d;
  logic signed [SAMPLE_W-1:0] play_s;
  logic signed [SAMPLE_W-1:0] in_s;
  logic signed [SAMPLE_W-1:0] mix_s;
  logic signed [SAMPLE_W-1:0] new_s;
  logic signed [SAMPLE_W-1:0] out_s;
  logic                       last_slot;
  logic                       writes_mem;

  // Slot k sits at the MSB end for k=0, moving toward the LSBs.
  function automatic logic signed [SAMPLE_W-1:0] get_slot(
      input logic [MEM_W-1:0] w, input int k);
    logic [MEM_W-1:0] sh;
    sh = w >> ((SPW - 1 - k) * SAMPLE_W);
    return $signed(sh[SAMPLE_W-1:0]);
  endfunction

  function automatic logic [MEM_W-1:0] set_slot(
      input logic [MEM_W-1:0] w, input int k, input logic signed [SAMPLE_W-1:0] s);
    logic [MEM_W-1:0] m;
    logic [MEM_W-1:0] v;
    m = MEM_W'({SAMPLE_W{1'b1}}) << ((SPW - 1 - k) * SAMPLE_W);
    v = MEM_W'($unsigned(s)) << ((SPW - 1 - k) * SAMPLE_W);
    return (w & ~m) | v;
  endfunction

  // One extra bit holds the true sum; a disagreement between the top two
  // bits means overflow, and the sign bit says which rail to clamp to.
  function automatic logic signed [SAMPLE_W-1:0] sat_add(
      input logic signed [SAMPLE_W-1:0] a, input logic signed [SAMPLE_W-1:0] b);
    logic signed [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
      return sum[SAMPLE_W] ? $signed({1'b1, {(SAMPLE_W-1){1'b0}}})
                           : $signed({1'b0, {(SAMPLE_W-1){1'b1}}});
    return sum[SAMPLE_W-1:0];
  endfunction

  // Per-ready datapath: played sample, mixed sample and next pack word.
  always_comb begin
    rd_sh      = mem_read >> (int'(bank_q) * MEM_W);
    rd_word    = rd_sh[MEM_W-1:0];
    cur_word   = (phase_q == '0) ? rd_word : play_q;
    play_s     = get_slot(cur_word, int'(phase_q));
    in_s       = $signed(audio_in);
    mix_s      = sat_add(play_s, in_s);
    new_s      = in_s;
    out_s      = play_s;
    case (mode_q)
      MODE_REC: begin new_s = in_s;  out_s = in_s;  end
      MODE_OVD: begin new_s = mix_s; out_s = mix_s; end
      default:  begin new_s = in_s;  out_s = play_s; end
    endcase
    pack_d     = set_slot(pack_q, int'(phase_q), new_s);
    last_slot  = (phase_q == PH_W'(SPW - 1));
    writes_mem = (mode_q == MODE_REC) || (mode_q == MODE_OVD);
  end

  // Control FSM with registered memory strobes and audio output.
  always_ff @(posedge clk) begin
    we_q       <= '0;
    word_adv_q <= 1'b0;
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_PLAY;
      bank_q      <= '0;
      phase_q     <= '0;
      pack_q      <= '0;
      play_q      <= '0;
      mem_write_q <= '0;
      audio_out_q <= '0;
    end else if (start_song) begin
      state_q <= RUN;
      mode_q  <= (mode == 2'b11) ? MODE_PLAY : mode;
      bank_q  <= song_choice[SONG_W-1 -: BANK_BITS];
      phase_q <= '0;
      pack_q  <= '0;
    end else begin
      case (state_q)
        RUN, PAUSE: begin
          if (song_done) begin
            // Flush a partially filled word; no address advance.
            if (writes_mem && phase_q != '0) begin
              mem_write_q <= pack_q;
              we_q        <= NUM_BANKS'(1) << bank_q;
            end
            state_q     <= DONE;
            phase_q     <= '0;
            pack_q      <= '0;
            audio_out_q <= '0;
          end else if (state_q == RUN && pause_song) begin
            state_q <= PAUSE;
          end else if (state_q == PAUSE) begin
            if (!pause_song) state_q <= RUN;
          end else if (ready) begin
            if (phase_q == '0) play_q <= rd_word;
            audio_out_q <= $unsigned(out_s);
            if (last_slot) begin
              if (writes_mem) begin
                mem_write_q <= pack_d;
                we_q        <= NUM_BANKS'(1) << bank_q;
              end
              word_adv_q <= 1'b1;
              pack_q     <= '0;
              phase_q    <= '0;
            end else begin
              if (writes_mem) pack_q <= pack_d;
              phase_q <= phase_q + 1'b1;
            end
          end
        end
        default: audio_out_q <= '0;
      endcase
    end
  end

  assign we        = we_q;
  assign mem_write = mem_write_q;
  assign word_adv  = word_adv_q;
  assign audio_out = audio_out_q;
  assign active    = (state_q == RUN);

endmodule

// File: tb/tb_audio_word_engine.sv
// Directed bench for audio_word_engine with hand-computed expectations.
module tb_audio_word_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [11:0] audio_in;
  logic        start_song;
  logic [3:0]  song_choice;
  logic [1:0]  mode;
  logic        pause_song;
  logic        song_done;
  logic [71:0] mem_read;
  logic [1:0]  we;
  logic [35:0] mem_write;
  logic        word_adv;
  logic [11:0] audio_out;
  logic        active;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int adv_cnt = 0;
  int we_snap;
  int adv_snap;

  audio_word_engine dut (
    .clk(clk), .reset(reset), .ready(ready), .audio_in(audio_in),
    .start_song(start_song), .song_choice(song_choice), .mode(mode),
    .pause_song(pause_song), .song_done(song_done), .mem_read(mem_read),
    .we(we), .mem_write(mem_write), .word_adv(word_adv),
    .audio_out(audio_out), .active(active)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (we != 2'b00) we_cnt++;
    if (word_adv)    adv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (4) tick();
  endtask

  task automatic rdy(input logic [11:0] s);
    audio_in = s;
    ready    = 1'b1;
    tick();
    ready    = 1'b0;
  endtask

  task automatic start(input logic [1:0] m, input logic [3:0] sc);
    mode        = m;
    song_choice = sc;
    start_song  = 1'b1;
    tick();
    start_song  = 1'b0;
    mode        = 2'b11;
    song_choice = 4'hF;
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; audio_in = '0; start_song = 1'b0;
    song_choice = '0; mode = 2'b00; pause_song = 1'b0; song_done = 1'b0;
    mem_read = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_we", we, 0);
    chk("rst_wdata", mem_write, 0);
    chk("rst_adv", word_adv, 0);
    chk("rst_aout", audio_out, 0);
    chk("rst_active", active, 0);
    rdy(12'h123);
    chk("idle_aout", audio_out, 0);
    gap();

    // Record into bank 1
    start(2'b01, 4'b1000);
    chk("rec_active", active, 1);
    gap();
    rdy(12'h111); chk("rec_mon", audio_out, 12'h111); gap();
    rdy(12'h222); chk("rec_nowe", we, 0); gap();
    rdy(12'h333);
    chk("rec_we", we, 2'b10);
    chk("rec_wdata", mem_write, 36'h111222333);
    chk("rec_adv", word_adv, 1);
    tick();
    chk("rec_we_1cyc", we, 0);
    chk("rec_adv_1cyc", word_adv, 0);
    chk("rec_wdata_hold", mem_write, 36'h111222333);
    gap();

    // Playback bank 0, buffer held after the first slot
    mem_read = {36'h999999999, 36'hABC123456};
    start(2'b00, 4'b0000);
    we_snap = we_cnt; adv_snap = adv_cnt;
    gap();
    rdy(12'h555); chk("pb_s0", audio_out, 12'hABC); gap();
    mem_read = '0;
    rdy(12'h555); chk("pb_s1", audio_out, 12'h123); gap();
    rdy(12'h555); chk("pb_s2", audio_out, 12'h456);
    chk("pb_adv", word_adv, 1);
    chk("pb_we", we, 0);
    gap();
    chk("pb_adv_cnt", adv_cnt - adv_snap, 1);
    chk("pb_we_cnt", we_cnt - we_snap, 0);

    // Overdub with saturation both ways
    mem_read = {36'h0, 36'h7F0800100};
    start(2'b10, 4'b0010);
    gap();
    rdy(12'h020); chk("od_pos_sat", audio_out, 12'h7FF); gap();
    rdy(12'hFFF); chk("od_neg_sat", audio_out, 12'h800); gap();
    rdy(12'h005); chk("od_plain", audio_out, 12'h105);
    chk("od_we", we, 2'b01);
    chk("od_wdata", mem_write, 36'h7FF800105);
    chk("od_adv", word_adv, 1);
    gap();

    // Pause: readies during pause are ignored
    start(2'b01, 4'b0000);
    we_snap = we_cnt;
    gap();
    rdy(12'h001); gap();
    rdy(12'h002); gap();
    pause_song = 1'b1;
    tick();
    chk("pause_active", active, 0);
    for (int i = 0; i < 4; i++) begin
      rdy(12'hEEE);
      chk("pause_hold", audio_out, 12'h002);
      gap();
    end
    chk("pause_nowe", we_cnt - we_snap, 0);
    pause_song = 1'b0;
    tick();
    chk("resume_active", active, 1);
    gap();
    rdy(12'h003);
    chk("pause_wdata", mem_write, 36'h001002003);
    chk("pause_we", we, 2'b01);
    gap();
    chk("pause_we_cnt", we_cnt - we_snap, 1);

    // Flush of a partial word on song_done
    start(2'b01, 4'b0000);
    gap();
    rdy(12'h00A); gap();
    rdy(12'h00B); gap();
    adv_snap = adv_cnt; we_snap = we_cnt;
    song_done = 1'b1;
    tick();
    song_done = 1'b0;
    chk("flush_we", we, 2'b01);
    chk("flush_wdata", mem_write, 36'h00A00B000);
    chk("flush_adv", word_adv, 0);
    chk("flush_active", active, 0);
    gap();
    rdy(12'h0CC); chk("done_aout", audio_out, 0); gap();
    rdy(12'h0CD); gap();
    rdy(12'h0CE); gap();
    chk("done_we_cnt", we_cnt - we_snap, 1);
    chk("done_adv_cnt", adv_cnt - adv_snap, 0);

    // start_song mid-word restarts packing without a write
    start(2'b01, 4'b0000);
    we_snap = we_cnt;
    gap();
    rdy(12'h0AA); gap();
    start(2'b01, 4'b0000);
    gap();
    rdy(12'h011); gap();
    rdy(12'h022); gap();
    chk("restart_nowe", we_cnt - we_snap, 0);
    rdy(12'h033);
    chk("restart_wdata", mem_write, 36'h011022033);
    gap();

    // Reset mid-word
    rdy(12'h044); gap();
    we_snap = we_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_we_cnt", we_cnt - we_snap, 0);
    chk("rst2_wdata", mem_write, 0);
    chk("rst2_aout", audio_out, 0);
    chk("rst2_active", active, 0);
    rdy(12'h077); chk("rst2_idle", audio_out, 0); gap();
    start(2'b01, 4'b1000);
    gap();
    rdy(12'h0D1); gap();
    rdy(12'h0D2); gap();
    rdy(12'h0D3);
    chk("rst2_wdata_new", mem_write, 36'h0D10D20D3);
    chk("rst2_we_new", we, 2'b10);
    gap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
